// File: rtl/sum_1ton_regfile_proc.sv
// Dedicated processor computing sum(i, i=1..N) for a run-time bound N.
// A control FSM sequences a 4-entry register file, an adder, a comparator and an output register.
module sum_1ton_regfile_proc #(
  parameter int DATA_W = 8,
  parameter int N_W    = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [N_W-1:0]    n_in,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] out,
  output logic              ovf
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    INIT_I = 3'd1,
    INIT_S = 3'd2,
    CMP    = 3'd3,
    ADD    = 3'd4,
    INC    = 3'd5,
    FIN    = 3'd6
  } state_t;

  state_t              state_r;
  logic [N_W-1:0]      n_reg_r;
  logic [DATA_W-1:0]   rf_r [0:3];
  logic                busy_r;
  logic                done_r;
  logic [DATA_W-1:0]   out_r;
  logic                ovf_r;

  logic [1:0]          ra_a_s;
  logic [1:0]          ra_b_s;
  logic [1:0]          wr_addr_s;
  logic                wr_en_s;
  logic                use_one_s;
  logic [DATA_W-1:0]   rd_a_s;
  logic [DATA_W-1:0]   rd_b_s;
  logic [DATA_W-1:0]   op_b_s;
  logic [DATA_W-1:0]   sum_s;
  logic                carry_s;
  logic                le_s;

  // R0 is hardwired to zero on both read ports
  assign rd_a_s = (ra_a_s == 2'd0) ? {DATA_W{1'b0}} : rf_r[ra_a_s];
  assign rd_b_s = (ra_b_s == 2'd0) ? {DATA_W{1'b0}} : rf_r[ra_b_s];
  assign op_b_s = use_one_s ? {{(DATA_W-1){1'b0}}, 1'b1} : rd_b_s;
  assign {carry_s, sum_s} = {1'b0, rd_a_s} + {1'b0, op_b_s};
  assign le_s = (rd_a_s <= {{(DATA_W-N_W){1'b0}}, n_reg_r});

  assign busy = busy_r;
  assign done = done_r;
  assign out  = out_r;
  assign ovf  = ovf_r;

  // Datapath control decode from the current state
  always_comb begin
    ra_a_s    = 2'd0;
    ra_b_s    = 2'd0;
    wr_addr_s = 2'd0;
    wr_en_s   = 1'b0;
    use_one_s = 1'b0;
    case (state_r)
      INIT_I: begin
        use_one_s = 1'b1;
        wr_en_s   = 1'b1;
        wr_addr_s = 2'd1;
      end
      INIT_S: begin
        wr_en_s   = 1'b1;
        wr_addr_s = 2'd2;
      end
      CMP: begin
        ra_a_s = 2'd1;
      end
      ADD: begin
        ra_a_s    = 2'd2;
        ra_b_s    = 2'd1;
        wr_en_s   = 1'b1;
        wr_addr_s = 2'd2;
      end
      INC: begin
        ra_a_s    = 2'd1;
        use_one_s = 1'b1;
        wr_en_s   = 1'b1;
        wr_addr_s = 2'd1;
      end
      FIN: begin
        ra_b_s = 2'd2;
      end
      default: begin
        ra_a_s    = 2'd0;
        ra_b_s    = 2'd0;
        wr_addr_s = 2'd0;
        wr_en_s   = 1'b0;
        use_one_s = 1'b0;
      end
    endcase
  end

  // Control FSM, register-file write port and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      n_reg_r <= {N_W{1'b0}};
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      out_r   <= {DATA_W{1'b0}};
      ovf_r   <= 1'b0;
      for (int k = 0; k < 4; k++) begin
        rf_r[k] <= {DATA_W{1'b0}};
      end
    end else begin
      done_r <= 1'b0;
      if (wr_en_s && (wr_addr_s != 2'd0)) begin
        rf_r[wr_addr_s] <= sum_s;
      end
      case (state_r)
        IDLE: begin
          if (start) begin
            n_reg_r <= n_in;
            ovf_r   <= 1'b0;
            busy_r  <= 1'b1;
            state_r <= INIT_I;
          end
        end
        INIT_I: state_r <= INIT_S;
        INIT_S: state_r <= CMP;
        CMP:    state_r <= le_s ? ADD : FIN;
        ADD: begin
          if (carry_s) begin
            ovf_r <= 1'b1;
          end
          state_r <= INC;
        end
        INC:    state_r <= CMP;
        FIN: begin
          out_r   <= rd_b_s;
          done_r  <= 1'b1;
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule
